// File: rtl/timer_sequencer_if.sv
// Start/abort/busy/done handshake plus the set/done pair toward one external timer.
// The sequencer drives the master side; the controller and timer together sit on the slave side.
interface timer_sequencer_if #(
    parameter int PHASE_W = 2
);
    logic               start;
    logic               abort;
    logic               tdone;
    logic               tset;
    logic [PHASE_W-1:0] phase;
    logic               busy;
    logic               done;
    logic               err;

    modport master (
        input  start, abort, tdone,
        output tset, phase, busy, done, err
    );

    modport slave (
        output start, abort, tdone,
        input  tset, phase, busy, done, err
    );
endinterface

// File: rtl/timer_sequencer.sv
// Steps through NUM_PHASES timed phases by pulsing tset and waiting on tdone.
// Optional stall watchdog is enabled with `define TIMER_SEQUENCER_WATCHDOG_EN.
module timer_sequencer #(
    parameter int NUM_PHASES      = 4,
    parameter int PHASE_W         = 2,
    parameter int WATCHDOG_CYCLES = 1024
) (
    input  logic               clk,
    input  logic               reset_n,
    timer_sequencer_if.master  bus
);

    generate
        if (NUM_PHASES < 1 || (1 << PHASE_W) < NUM_PHASES || WATCHDOG_CYCLES < 4) begin : g_param_check
            $error("timer_sequencer: illegal parameter combination");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_WAIT,
        S_NEXT,
        S_FINISH
`ifdef TIMER_SEQUENCER_WATCHDOG_EN
        , S_FAULT
`endif
    } state_t;

    localparam logic [PHASE_W-1:0] LAST_PHASE = PHASE_W'(NUM_PHASES - 1);

    state_t             state_reg, state_next;
    logic [PHASE_W-1:0] phase_reg, phase_next;
    logic               tset_reg, tset_next;
    logic               busy_reg, busy_next;
    logic               done_reg, done_next;
    // High during the first WAIT cycle, when the timer's done flag may still be stale.
    logic               blank_reg, blank_next;

`ifdef TIMER_SEQUENCER_WATCHDOG_EN
    localparam int             WD_W    = (WATCHDOG_CYCLES > 2) ? $clog2(WATCHDOG_CYCLES) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(WATCHDOG_CYCLES - 1);

    logic [WD_W-1:0] wdog_reg, wdog_next;
    logic            err_reg, err_next;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= S_IDLE;
            phase_reg <= '0;
            tset_reg  <= 1'b0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
            blank_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            phase_reg <= phase_next;
            tset_reg  <= tset_next;
            busy_reg  <= busy_next;
            done_reg  <= done_next;
            blank_reg <= blank_next;
        end
    end

`ifdef TIMER_SEQUENCER_WATCHDOG_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wdog_reg <= '0;
            err_reg  <= 1'b0;
        end else begin
            wdog_reg <= wdog_next;
            err_reg  <= err_next;
        end
    end
`endif

    always_comb begin
        state_next = state_reg;
        phase_next = phase_reg;
        blank_next = 1'b0;

        case (state_reg)
            S_IDLE: begin
                if (bus.start) begin
                    state_next = S_ARM;
                    phase_next = '0;
                end
            end
            S_ARM: begin
                if (bus.abort) begin
                    state_next = S_IDLE;
                    phase_next = '0;
                end else begin
                    state_next = S_WAIT;
                    blank_next = 1'b1;
                end
            end
            S_WAIT: begin
                // Abort outranks both a completed interval and a watchdog expiry.
                if (bus.abort) begin
                    state_next = S_IDLE;
                    phase_next = '0;
                end else if (!blank_reg && bus.tdone) begin
                    if (phase_reg == LAST_PHASE) begin
                        state_next = S_FINISH;
                    end else begin
                        state_next = S_NEXT;
                        phase_next = phase_reg + PHASE_W'(1);
                    end
                end
`ifdef TIMER_SEQUENCER_WATCHDOG_EN
                else if (wdog_reg == WD_LAST) begin
                    state_next = S_FAULT;
                end
`endif
            end
            S_NEXT: begin
                if (bus.abort) begin
                    state_next = S_IDLE;
                    phase_next = '0;
                end else begin
                    state_next = S_ARM;
                end
            end
            S_FINISH: begin
                state_next = S_IDLE;
                if (bus.abort) begin
                    phase_next = '0;
                end
            end
`ifdef TIMER_SEQUENCER_WATCHDOG_EN
            S_FAULT: begin
                if (bus.start) begin
                    state_next = S_ARM;
                    phase_next = '0;
                end
            end
`endif
            default: begin
                state_next = S_IDLE;
                phase_next = '0;
            end
        endcase

        // Outputs are registered copies of what the next state presents.
        tset_next = (state_next == S_ARM);
        busy_next = (state_next inside {S_ARM, S_WAIT, S_NEXT, S_FINISH});
        done_next = (state_next == S_FINISH);

`ifdef TIMER_SEQUENCER_WATCHDOG_EN
        wdog_next = (state_reg == S_WAIT) ? wdog_reg + WD_W'(1) : '0;
        err_next  = (state_next == S_FAULT);
`endif
    end

    assign bus.tset  = tset_reg;
    assign bus.phase = phase_reg;
    assign bus.busy  = busy_reg;
    assign bus.done  = done_reg;
`ifdef TIMER_SEQUENCER_WATCHDOG_EN
    assign bus.err   = err_reg;
`else
    assign bus.err   = 1'b0;
`endif

endmodule

// File: doc/timer_sequencer.md
# timer_sequencer

Initiator side of the timer set/done interface: steps through `NUM_PHASES` timed phases by pulsing a set line to an external timer and waiting for its done flag before advancing. It sits between the top-level control FSM and one timer instance, which holds done high until its next set. It adds a start/busy/done handshake, abort, and an optional stall watchdog.

## Interface
- `NUM_PHASES`, default 4: number of timed phases per run; must be ≥1.
- `PHASE_W`, default 2: width of `phase`; must satisfy 2^PHASE_W ≥ NUM_PHASES.
- `WATCHDOG_CYCLES`, default 1024: maximum WAIT cycles per phase before a fault; ≥4; used only with the watchdog feature.

Ports:
- `clk`  in  1  single clock; all logic on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  level; sampled in IDLE or FAULT to begin a run.
- `abort`  in  1  level; ends the current run with no done pulse.
- `tdone`  in  1  done flag from the timer; high = current interval expired.
- `tset`  out  1  one-cycle set pulse to the timer; restarts the interval and clears the timer's done flag.
- `phase`  out  PHASE_W  index of the current phase, 0..NUM_PHASES-1.
- `busy`  out  1  high while a run is in progress.
- `done`  out  1  one-cycle pulse when the last phase completes.
- `err`  out  1  sticky watchdog fault flag.

## Operation
- States: IDLE, ARM, WAIT, NEXT, FINISH, FAULT. All outputs are registered.
- Reset: state IDLE, `tset`=0, `phase`=0, `busy`=0, `done`=0, `err`=0, watchdog counter 0.
- IDLE: on `start`=1, go to ARM with `phase`=0.
- ARM: `tset`=1 for exactly this cycle; clear the watchdog counter; go to WAIT.
- WAIT:
  - Ignore `tdone` in the first WAIT cycle (blanking; the timer's done may still be stale).
  - From the second cycle on, `tdone`=1 goes to NEXT, or to FINISH if `phase`==NUM_PHASES-1.
- NEXT: `phase` increments by 1; go to ARM. `phase` never wraps within a run.
- FINISH: `done`=1 for this cycle; `phase` is held; go to IDLE.
- FAULT (watchdog only): `err`=1, `busy`=0, `tset`=0, `phase` held.
  - `start`=1 clears `err`, sets `phase`=0 and goes to ARM.
- `busy`=1 in ARM, WAIT, NEXT and FINISH; 0 in IDLE and FAULT.
- `abort`=1 in ARM, WAIT, NEXT or FINISH:
  - Next state IDLE, `phase`=0, `tset`=0, no `done` pulse.
  - Abort has priority over `tdone` and over the watchdog.
  - Abort in FINISH: the `done` pulse already driven this cycle stands.
- `start` is ignored while `busy`=1. `abort` in IDLE or FAULT has no effect.
- Same-cycle `start`+`abort` in IDLE/FAULT: the run starts; `abort` is evaluated from ARM onward.
- `reset_n` low mid-run immediately forces the reset values, including `tset`=0.

## Timing
- `start` sampled at edge E0. ARM is cycle 1 (`tset`=1, `busy`=1).
- Per non-final phase, minimum 4 cycles: ARM, WAIT (blank), WAIT (`tdone` seen), NEXT.
- Final phase ends in FINISH instead of NEXT, so minimum run length is 4·NUM_PHASES cycles. The `done` pulse falls in cycle 4·NUM_PHASES (16 for default); `busy` drops the following cycle.
- Back-to-back runs: `start` held high in the FINISH cycle is ignored (busy=1). A start sampled in the following IDLE cycle begins ARM one cycle later.
- Each extra cycle `tdone` stays low in WAIT adds one cycle to that phase.
- Abort takes effect on the next edge: `busy`=0 one cycle after `abort` is sampled.

## Configuration
- Macro `TIMER_SEQUENCER_WATCHDOG_EN`.
- Defined:
  - A counter of width ≥ clog2(WATCHDOG_CYCLES) counts WAIT cycles.
  - If the count reaches WATCHDOG_CYCLES-1 in WAIT with `tdone`=0, the next state is FAULT.
  - `tdone`=1 in that same cycle takes priority over the fault.
- Not defined: no counter and no FAULT state; WAIT waits indefinitely; `err` is tied to 0.

## Test plan
- Reset then idle: `reset_n` low → all outputs 0. Released with `start`=0 → outputs stay 0 for 20 cycles.
- Nominal run, NUM_PHASES=4, `tdone` returned 1 cycle after each `tset` → `tset` pulses in cycles 1,5,9,13; `phase` 0,1,2,3; `done`=1 only in cycle 16; `busy` high in cycles 1–16.
- Stale done: `tdone` held at 1 continuously → the blanking cycle is still honoured; same cycle counts as the nominal run, with no phase skipped.
- Abort: `abort`=1 in WAIT of phase 2 → IDLE next edge, `busy`=0, `phase`=0, no `done`; a new `start` restarts from phase 0.
- Watchdog (macro defined, WATCHDOG_CYCLES=8): `tdone` held 0 → FAULT after 8 WAIT cycles, `err`=1 sticky, `busy`=0; `start` clears `err` and pulses `tset`. Without the macro → stays in WAIT and `err`=0 for 100 cycles.
- Reset mid-run: `reset_n` driven low during ARM → `tset` falls asynchronously and all outputs return to reset values before the next edge.
